// File: rtl/pc_seq_pkg.sv
// Shared types and sizing helpers for the PC sequencer.
// Latency: n/a (types only).
// Backpressure: n/a.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } seq_state_t;

    // Wait counter width; kept at least 1 bit so MulCycles=2 still yields a legal vector.
    function automatic int cnt_width(input int mul_cycles);
        return (mul_cycles > 2) ? $clog2(mul_cycles) : 1;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Decoder/PC-side bundle of the PC sequencer; call/ret exist only with PC_SEQ_CALL_RET_EN.
// Latency: wires only.
// Backpressure: none, the PC accepts a PCup/BranchAddress pair every cycle.
interface pc_sequencer_if #(
    parameter int Psize = 5
);
    logic [Psize-1:0] pc_in;
    logic             branch;
    logic             cbranch;
    logic             flag;
    logic [Psize-1:0] target;
    logic             multi;
    logic             halt;
`ifdef PC_SEQ_CALL_RET_EN
    logic             call;
    logic             ret;
`endif
    logic             PCup;
    logic [Psize-1:0] BranchAddress;
    logic             op_done;
    logic             busy;
    logic             halted;

    modport master (
`ifdef PC_SEQ_CALL_RET_EN
        output call, output ret,
`endif
        output pc_in, output branch, output cbranch, output flag,
        output target, output multi, output halt,
        input  PCup, input BranchAddress, input op_done, input busy, input halted
    );

    modport slave (
`ifdef PC_SEQ_CALL_RET_EN
        input  call, input ret,
`endif
        input  pc_in, input branch, input cbranch, input flag,
        input  target, input multi, input halt,
        output PCup, output BranchAddress, output op_done, output busy, output halted
    );

endinterface

// File: rtl/pc_sequencer_wait_cnt.sv
// Loadable down-counter (module seq_wait_cnt) timing the hold of a multi-cycle instruction.
// Latency: load/decrement take effect at the next edge; zero is combinational from the count.
// Backpressure: none.
module seq_wait_cnt
    import pc_seq_pkg::*;
#(
    parameter int MulCycles = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int CW = cnt_width(MulCycles);

    logic [CW-1:0] cnt;

    // The RUN cycle that accepts the instruction is the first of MulCycles, hence the -2.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(MulCycles - 2);
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: drives PCup/BranchAddress for step, branch, multi-cycle stall and halt (call/ret with PC_SEQ_CALL_RET_EN).
// Latency: PCup/BranchAddress are combinational, so the PC acts on them at the very next edge.
// Backpressure: none; holding is done by reloading pc_in into the PC.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int Psize     = 5,
    parameter int MulCycles = 4
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  sq
);

    seq_state_t       state, state_nxt;
    logic             wait_load, wait_dec, wait_zero;
    logic             pcup, op_done, busy, halted;
    logic [Psize-1:0] baddr;
    logic             taken;
`ifdef PC_SEQ_CALL_RET_EN
    logic [Psize-1:0] link, link_nxt;
`endif

    assign taken = sq.branch | (sq.cbranch & sq.flag);

    seq_wait_cnt #(.MulCycles(MulCycles)) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (wait_load),
        .dec   (wait_dec),
        .zero  (wait_zero)
    );

    always_comb begin
        pcup      = 1'b0;
        baddr     = sq.target;
        op_done   = 1'b0;
        busy      = 1'b0;
        halted    = 1'b0;
        wait_load = 1'b0;
        wait_dec  = 1'b0;
        state_nxt = state;
`ifdef PC_SEQ_CALL_RET_EN
        link_nxt  = link;
`endif
        // Loading 0 during reset forces the PC home regardless of its own reset.
        if (reset) begin
            baddr     = '0;
            state_nxt = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (sq.halt) begin
                        baddr     = sq.pc_in;
                        state_nxt = HALT;
                    end else if (sq.multi) begin
                        baddr     = sq.pc_in;
                        busy      = 1'b1;
                        wait_load = 1'b1;
                        state_nxt = WAIT;
`ifdef PC_SEQ_CALL_RET_EN
                    end else if (sq.call) begin
                        baddr     = sq.target;
                        link_nxt  = sq.pc_in + Psize'(1);
                    end else if (sq.ret) begin
                        baddr     = link;
`endif
                    end else if (taken) begin
                        baddr     = sq.target;
                    end else begin
                        pcup      = 1'b1;
                    end
                end
                WAIT: begin
                    busy = 1'b1;
                    if (wait_zero) begin
                        pcup      = 1'b1;
                        op_done   = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        baddr     = sq.pc_in;
                        wait_dec  = 1'b1;
                    end
                end
                HALT: begin
                    baddr  = sq.pc_in;
                    halted = 1'b1;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
`ifdef PC_SEQ_CALL_RET_EN
            link  <= '0;
`endif
        end else begin
            state <= state_nxt;
`ifdef PC_SEQ_CALL_RET_EN
            link  <= link_nxt;
`endif
        end
    end

    assign sq.PCup          = pcup;
    assign sq.BranchAddress = baddr;
    assign sq.op_done       = op_done;
    assign sq.busy          = busy;
    assign sq.halted        = halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vectors, a cycle-count model of PC control, and literal pins.
// Covers call/ret vectors when PC_SEQ_CALL_RET_EN is defined.
module tb_pc_sequencer;

    localparam int PSIZE = 5;
    localparam int MUL   = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pc_sequencer_if #(.Psize(PSIZE)) bus ();

    pc_sequencer #(.Psize(PSIZE), .MulCycles(MUL)) dut (
        .clk   (clk),
        .reset (reset),
        .sq    (bus)
    );

    typedef struct {
        bit       rst;
        int       pc;
        bit       br, cbr, fl;
        int       tgt;
        bit       mul, hlt, cl, rt;
        bit       lit;
        bit       l_pcup;
        int       l_ba;
        bit       l_op, l_busy, l_hlt;
    } vec_t;

    vec_t vq[$];
    vec_t cur;
    int   cyc = -1;
    bit   active = 1'b0;
    int   checks = 0;
    int   fails = 0;

    // Model state: halted flag, remaining cycles of a multi-cycle hold, link value.
    bit m_halted = 1'b0;
    int m_stall = 0;
    int m_link = 0;
    bit n_halted;
    int n_stall;
    int n_link;
    bit pend = 1'b0;

    task automatic add_v(input bit rst, input int pc, input bit br, input bit cbr, input bit fl,
                         input int tgt, input bit mul, input bit hlt, input bit cl, input bit rt,
                         input bit lit, input bit l_pcup, input int l_ba,
                         input bit l_op, input bit l_busy, input bit l_hlt);
        vec_t v;
        v.rst = rst; v.pc = pc; v.br = br; v.cbr = cbr; v.fl = fl; v.tgt = tgt;
        v.mul = mul; v.hlt = hlt; v.cl = cl; v.rt = rt;
        v.lit = lit; v.l_pcup = l_pcup; v.l_ba = l_ba;
        v.l_op = l_op; v.l_busy = l_busy; v.l_hlt = l_hlt;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL cyc%0d %s: got %0d expected %0d", cyc, name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        reset           = v.rst;
        bus.pc_in       = PSIZE'(v.pc);
        bus.branch      = v.br;
        bus.cbranch     = v.cbr;
        bus.flag        = v.fl;
        bus.target      = PSIZE'(v.tgt);
        bus.multi       = v.mul;
        bus.halt        = v.hlt;
`ifdef PC_SEQ_CALL_RET_EN
        bus.call        = v.cl;
        bus.ret         = v.rt;
`endif
    endtask

    always @(negedge clk) begin
        bit e_pcup, e_op, e_busy, e_hlt;
        int e_ba;
        if (active) begin
            e_pcup = 0; e_op = 0; e_busy = 0; e_hlt = 0; e_ba = 0;
            n_halted = m_halted; n_stall = m_stall; n_link = m_link;
            if (cur.rst) begin
                n_halted = 0; n_stall = 0; n_link = 0;
            end else if (m_halted) begin
                e_ba = cur.pc; e_hlt = 1;
            end else if (m_stall > 0) begin
                e_busy = 1;
                n_stall = m_stall - 1;
                if (m_stall == 1) begin e_pcup = 1; e_op = 1; end
                else e_ba = cur.pc;
            end else if (cur.hlt) begin
                e_ba = cur.pc; n_halted = 1;
            end else if (cur.mul) begin
                e_ba = cur.pc; e_busy = 1; n_stall = MUL - 1;
`ifdef PC_SEQ_CALL_RET_EN
            end else if (cur.cl) begin
                e_ba = cur.tgt; n_link = (cur.pc + 1) % (2 ** PSIZE);
            end else if (cur.rt) begin
                e_ba = m_link;
`endif
            end else if (cur.br || (cur.cbr && cur.fl)) begin
                e_ba = cur.tgt;
            end else begin
                e_pcup = 1;
            end
            check("PCup", int'(bus.PCup), int'(e_pcup));
            if (!e_pcup) check("BranchAddress", int'(bus.BranchAddress), e_ba);
            check("op_done", int'(bus.op_done), int'(e_op));
            check("busy", int'(bus.busy), int'(e_busy));
            check("halted", int'(bus.halted), int'(e_hlt));
            if (cur.lit) begin
                check("lit_PCup", int'(bus.PCup), int'(cur.l_pcup));
                if (!cur.l_pcup) check("lit_BranchAddress", int'(bus.BranchAddress), cur.l_ba);
                check("lit_op_done", int'(bus.op_done), int'(cur.l_op));
                check("lit_busy", int'(bus.busy), int'(cur.l_busy));
                check("lit_halted", int'(bus.halted), int'(cur.l_hlt));
            end
            pend = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (pend) begin
            m_halted = n_halted;
            m_stall  = n_stall;
            m_link   = n_link;
            pend     = 1'b0;
        end
    end

    initial begin
        //     rst pc br cb fl tgt mu ha ca re  lit pcup ba op bsy hlt
        add_v(1,  7, 1, 0, 0, 3,  0, 0, 0, 0,  1, 0,  0, 0, 0, 0);
        add_v(1,  7, 1, 0, 0, 3,  0, 0, 0, 0,  1, 0,  0, 0, 0, 0);
        add_v(0,  7, 0, 0, 0, 0,  0, 0, 0, 0,  1, 1,  0, 0, 0, 0);
        add_v(0,  3, 1, 0, 0, 20, 0, 0, 0, 0,  1, 0, 20, 0, 0, 0);
        add_v(0, 20, 0, 1, 0, 2,  0, 0, 0, 0,  1, 1,  0, 0, 0, 0);
        add_v(0, 20, 0, 1, 1, 5,  0, 0, 0, 0,  1, 0,  5, 0, 0, 0);
        add_v(0,  9, 0, 0, 0, 0,  1, 0, 0, 0,  1, 0,  9, 0, 1, 0);
        add_v(0,  9, 1, 0, 0, 1,  0, 0, 0, 0,  1, 0,  9, 0, 1, 0);
        add_v(0,  9, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0,  9, 0, 1, 0);
        add_v(0,  9, 0, 0, 0, 0,  0, 0, 0, 0,  1, 1,  0, 1, 1, 0);
        add_v(0, 10, 0, 0, 0, 0,  0, 0, 0, 0,  1, 1,  0, 0, 0, 0);
        add_v(0, 31, 0, 0, 0, 0,  0, 0, 0, 0,  1, 1,  0, 0, 0, 0);
        add_v(0, 12, 1, 0, 0, 3,  0, 1, 0, 0,  1, 0, 12, 0, 0, 0);
        add_v(0, 12, 1, 0, 0, 3,  0, 0, 0, 0,  1, 0, 12, 0, 0, 1);
        add_v(0, 12, 0, 0, 0, 0,  1, 0, 0, 0,  1, 0, 12, 0, 0, 1);
        add_v(1, 12, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0,  0, 0, 0, 0);
        add_v(0, 12, 0, 0, 0, 0,  0, 0, 0, 0,  1, 1,  0, 0, 0, 0);
        add_v(0,  8, 0, 0, 0, 0,  1, 0, 0, 0,  1, 0,  8, 0, 1, 0);
        add_v(0,  8, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0,  8, 0, 1, 0);
        add_v(1,  8, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0,  0, 0, 0, 0);
        add_v(0,  8, 0, 0, 0, 0,  0, 0, 0, 0,  1, 1,  0, 0, 0, 0);
        add_v(0,  8, 0, 0, 0, 0,  0, 0, 0, 0,  1, 1,  0, 0, 0, 0);
        add_v(0,  6, 1, 0, 0, 6,  0, 0, 0, 0,  1, 0,  6, 0, 0, 0);
        add_v(0,  4, 1, 0, 0, 9,  1, 1, 0, 0,  1, 0,  4, 0, 0, 0);
        add_v(0,  4, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0,  4, 0, 0, 1);
        add_v(1,  4, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0,  0, 0, 0, 0);
        add_v(0,  2, 1, 1, 1, 17, 1, 0, 0, 0,  1, 0,  2, 0, 1, 0);
        add_v(0,  2, 0, 0, 0, 0,  0, 1, 0, 0,  1, 0,  2, 0, 1, 0);
        add_v(0,  2, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0,  2, 0, 1, 0);
        add_v(0,  2, 1, 0, 0, 11, 0, 0, 0, 0,  1, 1,  0, 1, 1, 0);
        add_v(0,  3, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0,  0, 0, 0, 0);
`ifdef PC_SEQ_CALL_RET_EN
        add_v(0, 31, 0, 0, 0, 4,  0, 0, 1, 0,  1, 0,  4, 0, 0, 0);
        add_v(0,  4, 0, 0, 0, 0,  0, 0, 0, 1,  1, 0,  0, 0, 0, 0);
        add_v(0,  0, 1, 0, 0, 9,  0, 0, 1, 1,  1, 0,  9, 0, 0, 0);
        add_v(0,  9, 1, 0, 0, 20, 0, 0, 0, 1,  1, 0,  1, 0, 0, 0);
        add_v(0,  1, 0, 0, 0, 0,  0, 0, 0, 0,  1, 1,  0, 0, 0, 0);
`endif

        apply(vq[0]);
        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk);
            #1;
            apply(vq[i]);
            cur    = vq[i];
            cyc    = i;
            active = 1'b1;
        end
        @(posedge clk);
        #1;
        active = 1'b0;
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
